rs_syndrome_calc: RTL and testbench

RS_SYNDROME_CALC -- requirements
Module: rs_syndrome_calc

---
 rtl/rs_syndrome_calc_if.sv | 38 +++
 rtl/rs_syndrome_calc.sv | 111 +++++++++++
 tb/tb_rs_syndrome_calc.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rs_syndrome_calc_if.sv
// Handshake and data bundle between a codeword source and rs_syndrome_calc.
// master = word source / result consumer, slave = syndrome calculator.
// Optional errCount signal present only when RS_SYND_ERRCOUNT_EN is defined.
interface rs_syndrome_calc_if;
  logic [59:0] codeWord;
  logic        startIn;
  logic        busy;
  logic [23:0] syndromes;
  logic        syndValid;
  logic        errorDetected;
`ifdef RS_SYND_ERRCOUNT_EN
  logic [15:0] errCount;
`endif

  modport master (
    output codeWord,
    output startIn,
    input  busy,
    input  syndromes,
    input  syndValid,
    input  errorDetected
`ifdef RS_SYND_ERRCOUNT_EN
    ,input errCount
`endif
  );

  modport slave (
    input  codeWord,
    input  startIn,
    output busy,
    output syndromes,
    output syndValid,
    output errorDetected
`ifdef RS_SYND_ERRCOUNT_EN
    ,output errCount
`endif
  );
endinterface

// File: rtl/rs_syndrome_calc.sv
// RS(15,9) syndrome calculator over GF(16) (x^4+x+1): S1..S6 by Horner's rule, one symbol per cycle.
// Latency: start accepted at edge k, syndromes + syndValid pulse at edge k+15; one result per 16 cycles.
// Backpressure: none; startIn while busy is dropped. Macro RS_SYND_ERRCOUNT_EN adds errCount.
module rs_syndrome_calc (
  input logic            clk,
  input logic            rstN,
  rs_syndrome_calc_if.slave bus
);

  typedef enum logic {IDLE, ACCUM} state_t;

  // alpha^1..alpha^6 packed as nibbles, alpha^j at [4(j-1)+:4]
  localparam logic [23:0] ALPHA_POWS = 24'hC63842;

  // GF(16) multiply, shift-and-add with reduction by x^4 = x + 1
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] x;
    p = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'b0011 : 4'b0000);
    end
    return p;
  endfunction

  state_t      r_state;
  logic [59:0] r_word;
  logic [3:0]  r_cnt;
  logic [23:0] r_acc;
  logic        r_busy;
  logic [23:0] r_synd;
  logic        r_valid;
  logic        r_err;

  logic [3:0]  w_sym;
  logic [23:0] w_next;

  assign w_sym = r_word[{r_cnt, 2'b00} +: 4];

  // One Horner step for all six syndromes in parallel
  always_comb begin
    w_next = 24'h0;
    for (int j = 0; j < 6; j++) begin
      w_next[4*j +: 4] = gf_mul(r_acc[4*j +: 4], ALPHA_POWS[4*j +: 4]) ^ w_sym;
    end
  end

  // Control FSM plus datapath registers; the final step loads outputs directly
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= IDLE;
      r_word  <= 60'h0;
      r_cnt   <= 4'd0;
      r_acc   <= 24'h0;
      r_busy  <= 1'b0;
      r_synd  <= 24'h0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.startIn) begin
            r_word  <= bus.codeWord;
            r_acc   <= 24'h0;
            r_cnt   <= 4'd14;
            r_busy  <= 1'b1;
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          r_acc <= w_next;
          if (r_cnt == 4'd0) begin
            // c0 consumed: publish and leave without decrementing
            r_synd  <= w_next;
            r_err   <= |w_next;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.syndromes     = r_synd;
  assign bus.syndValid     = r_valid;
  assign bus.errorDetected = r_err;

`ifdef RS_SYND_ERRCOUNT_EN
  logic [15:0] r_err_count;

  // Saturating count of completions that found a nonzero syndrome
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_err_count <= 16'h0;
    end else if (r_state == ACCUM && r_cnt == 4'd0 && (|w_next) && r_err_count != 16'hFFFF) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign bus.errCount = r_err_count;
`endif

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Directed bench for rs_syndrome_calc: known codewords with hand-computed syndromes,
// protocol timing (latency, held start, mid-op word change) and mid-operation reset.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_rs_syndrome_calc;

  logic clk;
  logic rstN;
  int   n_chk;
  int   n_fail;

  rs_syndrome_calc_if u_if();

  rs_syndrome_calc dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (u_if)
  );

  localparam logic [59:0] CW_ZERO  = 60'h0;
  localparam logic [59:0] CW_VALID = 60'h000000001793CAC;
  localparam logic [59:0] CW_E0    = 60'h000000001793CAD;
  localparam logic [59:0] CW_E1    = 60'h000000001793CBC;
  localparam logic [59:0] CW_E01   = 60'h000000001793CBD;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Present a word with startIn for one edge; returns just after the accept edge k
  task automatic start_word(input logic [59:0] cw);
    @(negedge clk);
    u_if.codeWord = cw;
    u_if.startIn  = 1'b1;
    @(negedge clk);
    u_if.startIn  = 1'b0;
  endtask

  // Wait (bounded) for syndValid and check latency, outputs and pulse width
  task automatic wait_result(input string tag, input int exp_lat,
                             input logic [23:0] exp_synd, input logic exp_err);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!u_if.syndValid && lat < 40);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_synd"}, u_if.syndromes, exp_synd);
    chk({tag, "_err"}, u_if.errorDetected, exp_err);
    chk({tag, "_busy_done"}, u_if.busy, 1'b0);
    @(negedge clk);
    chk({tag, "_valid_drop"}, u_if.syndValid, 1'b0);
    chk({tag, "_synd_hold"}, u_if.syndromes, exp_synd);
  endtask

  task automatic run_word(input string tag, input logic [59:0] cw,
                          input logic [23:0] exp_synd, input logic exp_err);
    start_word(cw);
    chk({tag, "_busy"}, u_if.busy, 1'b1);
    wait_result(tag, 15, exp_synd, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int first_at;
    int second_at;
    bit saw_valid;
    n_chk  = 0;
    n_fail = 0;
    rstN          = 1'b0;
    u_if.startIn  = 1'b0;
    u_if.codeWord = 60'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", u_if.busy, 1'b0);
    chk("rst_valid", u_if.syndValid, 1'b0);
    chk("rst_synd", u_if.syndromes, 24'h0);
    chk("rst_err", u_if.errorDetected, 1'b0);
`ifdef RS_SYND_ERRCOUNT_EN
    chk("rst_errcnt", u_if.errCount, 16'h0);
`endif
    rstN = 1'b1;

    run_word("zero",  CW_ZERO,  24'h000000, 1'b0);
    run_word("valid", CW_VALID, 24'h000000, 1'b0);
    run_word("err_c0", CW_E0,   24'h111111, 1'b1);
    run_word("err_c1", CW_E1,   24'hC63842, 1'b1);
    run_word("err_c0c1", CW_E01, 24'hD72953, 1'b1);
`ifdef RS_SYND_ERRCOUNT_EN
    chk("errcnt_3", u_if.errCount, 16'd3);
`endif

    // startIn held for 40 edges: accepts at k and k+16 inside the window
    @(negedge clk);
    u_if.codeWord = CW_VALID;
    u_if.startIn  = 1'b1;
    pulses = 0;
    first_at = -1;
    second_at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (u_if.syndValid) begin
        pulses++;
        if (first_at < 0) first_at = i;
        else if (second_at < 0) second_at = i;
      end
    end
    u_if.startIn = 1'b0;
    chk("held_pulses", pulses, 2);
    chk("held_first", first_at, 15);
    chk("held_second", second_at, 31);
    repeat (20) @(negedge clk);
    chk("held_idle", u_if.busy, 1'b0);

    // Word changed at k+5 must not disturb the latched copy
    start_word(CW_E0);
    repeat (4) @(negedge clk);
    u_if.codeWord = CW_ZERO;
    wait_result("cw_change", 11, 24'h111111, 1'b1);

    // Reset asserted ahead of edge k+7 aborts without a result
    start_word(CW_E1);
    repeat (6) @(negedge clk);
    rstN = 1'b0;
    #1;
    chk("abort_busy", u_if.busy, 1'b0);
    chk("abort_valid", u_if.syndValid, 1'b0);
    chk("abort_synd", u_if.syndromes, 24'h0);
    chk("abort_err", u_if.errorDetected, 1'b0);
`ifdef RS_SYND_ERRCOUNT_EN
    chk("abort_errcnt", u_if.errCount, 16'h0);
`endif
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u_if.syndValid) saw_valid = 1'b1;
    end
    chk("abort_no_pulse", saw_valid, 1'b0);
    chk("abort_synd_after", u_if.syndromes, 24'h0);

    run_word("post_rst", CW_E1, 24'hC63842, 1'b1);
`ifdef RS_SYND_ERRCOUNT_EN
    chk("post_rst_errcnt", u_if.errCount, 16'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
